rx_fifo: RTL and testbench



---
 rtl/rx_fifo.sv | 168 ++++++++++++++++
 tb/tb_rx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// rx_fifo: receive-side buffer behind the UART receiver.
//   A capture FSM watches the receiver's valid level. It pushes one
//   {paritye, framee, overrune, letter} entry per character and returns a
//   one-cycle readen acknowledge. Entries are held in a
//   first-word-fall-through FIFO that has a sticky overflow flag.
//
// Optional feature (macro RXF_FRAMEERR_PUSH_EN):
//   When the macro is defined, a rising edge of framee_in seen in IDLE while
//   valid_in=0 also pushes an entry, with its framee bit set and no readen.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   valid_in      : receiver valid level, held until acknowledged
//   letter_in     : receiver data byte
//   paritye_in    : receiver parity-error flag
//   framee_in     : receiver framing-error flag
//   overrune_in   : receiver overrun flag
//   readen        : registered acknowledge pulse to the receiver
//   rd_en         : host pop request (ignored while empty)
//   dout          : head entry {paritye, framee, overrune, letter}; FWFT
//   empty, full   : FIFO status, derived from count
//   count         : number of stored entries, 0..DEPTH
//   ovf           : sticky flag, set when a character is dropped on full
//   clr_ovf       : clears ovf (a set in the same cycle wins)
module rx_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned EW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [7:0]    letter_in,
  input  logic          paritye_in,
  input  logic          framee_in,
  input  logic          overrune_in,
  output logic          readen,
  input  logic          rd_en,
  output logic [EW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          clr_ovf
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          readen_q, readen_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          push_req_c;
  logic [EW-1:0] push_data_c;
  logic          empty_c, full_c, pop_c, push_ok_c, drop_c;

  logic [EW-1:0] mem_q [DEPTH];

`ifdef RXF_FRAMEERR_PUSH_EN
  // Previous framee_in value, used to detect its rising edge.
  logic framee_q;

  always_ff @(posedge clk) begin
    if (reset) framee_q <= 1'b0;
    else       framee_q <= framee_in;
  end
`endif

  // State and acknowledge registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      readen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      readen_q <= readen_d;
    end
  end

  // Capture FSM. WAIT_LOW holds until valid drops, so each character is
  // pushed once however long the receiver keeps valid high.
  always_comb begin
    state_d     = state_q;
    readen_d    = 1'b0;
    push_req_c  = 1'b0;
    push_data_c = EW'({paritye_in, framee_in, overrune_in, letter_in});
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          push_req_c = 1'b1;
          readen_d   = 1'b1;
          state_d    = ACK;
        end
`ifdef RXF_FRAMEERR_PUSH_EN
        else if (framee_in && !framee_q) begin
          // The receiver holds no valid for this frame, so no readen is sent.
          push_req_c  = 1'b1;
          push_data_c = EW'({paritye_in, 1'b1, overrune_in, letter_in});
        end
`endif
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!valid_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FIFO control. A pop in the same cycle frees the slot for a push on full.
  always_comb begin
    empty_c   = (count_q == '0);
    full_c    = (count_q == FULL_CNT);
    pop_c     = rd_en && !empty_c;
    push_ok_c = push_req_c && (!full_c || pop_c);
    drop_c    = push_req_c && full_c && !pop_c;

    wr_ptr_d  = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A set has priority over clr_ovf.
    if (drop_c)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array. It has no reset; stale contents are unreachable once the
  // pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data_c;
  end

  assign readen = readen_q;
  assign dout   = mem_q[rd_ptr_q];
  assign empty  = empty_c;
  assign full   = full_c;
  assign count  = count_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo. It drives inputs 1 ns after each rising edge
// and samples outputs at that same point.
module tb_rx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [7:0]  letter_in;
  logic        paritye_in, framee_in, overrune_in;
  logic        readen;
  logic        rd_en;
  logic [10:0] dout;
  logic        empty, full;
  logic [4:0]  count;
  logic        ovf;
  logic        clr_ovf;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;
  logic p;

  rx_fifo #(.AW(4), .EW(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .letter_in   (letter_in),
    .paritye_in  (paritye_in),
    .framee_in   (framee_in),
    .overrune_in (overrune_in),
    .readen      (readen),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .ovf         (ovf),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one character as a well-behaved receiver. Valid stays high until
  // after the acknowledge. The task returns the readen value seen after the
  // capture edge.
  task automatic send(input logic [7:0] l, input logic pe, input logic oe, output logic pulse);
    letter_in   = l;
    paritye_in  = pe;
    overrune_in = oe;
    valid_in    = 1'b1;
    tick();
    pulse = readen;
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; letter_in = '0; paritye_in = 1'b0;
    framee_in = 1'b0; overrune_in = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    check("rst_readen", 32'(readen), 32'd0);
    check("rst_empty",  32'(empty),  32'd1);
    check("rst_full",   32'(full),   32'd0);
    check("rst_count",  32'(count),  32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    reset = 1'b0;
    tick();

    // Single character 0x41.
    letter_in = 8'h41; valid_in = 1'b1;
    tick();
    check("c1_readen_hi", 32'(readen), 32'd1);
    check("c1_dout",      32'(dout),   32'h041);
    check("c1_count",     32'(count),  32'd1);
    check("c1_empty",     32'(empty),  32'd0);
    tick();
    check("c1_readen_lo", 32'(readen), 32'd0);
    tick();
    valid_in = 1'b0;
    tick();
    check("c1_readen_end", 32'(readen), 32'd0);
    check("c1_count_end",  32'(count),  32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("c1_pop_empty", 32'(empty), 32'd1);

    // Valid held high for 10 cycles after the acknowledge.
    letter_in = 8'h42; valid_in = 1'b1;
    tick();
    check("hold_readen", 32'(readen), 32'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (readen) pulses++;
    end
    check("hold_no_repulse", 32'(pulses), 32'd0);
    check("hold_count",      32'(count),  32'd1);
    valid_in = 1'b0; tick();
    check("hold_dout", 32'(dout), 32'h042);
    rd_en = 1'b1; tick(); rd_en = 1'b0;

    // Fill with 0x00..0x0F, then overflow with 0x10.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, 1'b0, p);
      if (p) pulses++;
    end
    check("fill_pulses", 32'(pulses), 32'd16);
    check("fill_full",   32'(full),   32'd1);
    check("fill_count",  32'(count),  32'd16);
    check("fill_ovf0",   32'(ovf),    32'd0);
    send(8'h10, 1'b0, 1'b0, p);
    check("ovf_readen", 32'(p),     32'd1);
    check("ovf_set",    32'(ovf),   32'd1);
    check("ovf_count",  32'(count), 32'd16);
    check("ovf_full",   32'(full),  32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(dout), 32'(i));
      tick();
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);

    // Full FIFO: a push in the same cycle as a pop is accepted.
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0, p);
    letter_in = 8'h77; valid_in = 1'b1; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pp_readen", 32'(readen), 32'd1);
    check("pp_count",  32'(count),  32'd16);
    check("pp_ovf",    32'(ovf),    32'd0);
    check("pp_head",   32'(dout),   32'h001);
    tick(); valid_in = 1'b0; tick();
    rd_en = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    rd_en = 1'b0;
    check("pp_last",       32'(dout),  32'h077);
    check("pp_last_count", 32'(count), 32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("pp_empty", 32'(empty), 32'd1);

    // Flags are carried into the entry.
    send(8'h55, 1'b1, 1'b1, p);
    check("flags_dout", 32'(dout), 32'h555);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("flags_ovf", 32'(ovf), 32'd0);
    paritye_in = 1'b0; overrune_in = 1'b0;
    rd_en = 1'b1; tick(); tick(); rd_en = 1'b0;
    check("pop_when_empty_count", 32'(count), 32'd0);
    check("pop_when_empty_empty", 32'(empty), 32'd1);

    // Reset during ACK, with valid still high across reset release.
    letter_in = 8'h66; valid_in = 1'b1;
    tick();
    check("ra_readen_pre", 32'(readen), 32'd1);
    reset = 1'b1; tick();
    check("ra_readen", 32'(readen), 32'd0);
    check("ra_count",  32'(count),  32'd0);
    check("ra_empty",  32'(empty),  32'd1);
    reset = 1'b0; tick();
    check("ra_recapture_readen", 32'(readen), 32'd1);
    check("ra_recapture_dout",   32'(dout),   32'h066);
    tick(); valid_in = 1'b0; tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("ra_drain", 32'(count), 32'd0);

    // Framing-error rising edge while valid_in is low.
    letter_in = 8'h3C; framee_in = 1'b1;
    tick();
    check("fe_readen", 32'(readen), 32'd0);
`ifdef RXF_FRAMEERR_PUSH_EN
    check("fe_count", 32'(count), 32'd1);
    check("fe_dout",  32'(dout),  32'h23C);
    tick();
    check("fe_once", 32'(count), 32'd1);
`else
    check("fe_count", 32'(count), 32'd0);
    tick();
    check("fe_once", 32'(count), 32'd0);
`endif
    framee_in = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
